// File: rtl/eth_rx_drain_pkg.sv
// Shared definitions for the receive drain engine.
// Holds the controller register map, access-size codes, FSM state encoding and
// the helper that builds the byte-keep mask for the final beat of a frame.
package eth_rx_drain_pkg;

  // Controller register map
  localparam logic [15:0] RegRxSize  = 16'h1004;
  localparam logic [15:0] RegRxPend  = 16'h1010;
  localparam logic [15:0] RegRxIntEn = 16'h1014;
  localparam logic [15:0] RegBufBase = 16'h0000;

  // Register-port access sizes
  localparam logic [1:0] OpSize4 = 2'b10;
  localparam logic [1:0] OpSize8 = 2'b11;

  typedef enum logic [2:0] {
    StInit   = 3'd0,
    StIdle   = 3'd1,
    StRdPend = 3'd2,
    StRdSize = 3'd3,
    StRdData = 3'd4,
    StStream = 3'd5,
    StClear  = 3'd6,
    StDrop   = 3'd7
  } state_e;

  // Keep mask for the last beat: low 'rem' bytes valid, or all bytes when the
  // frame ends on a word boundary.
  function automatic logic [7:0] last_keep(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : ((8'h01 << rem) - 8'h01);
  endfunction

endpackage

// File: rtl/eth_rx_drain.sv
// Receive drain engine for ethernet_controller.
// Replaces software polling: on an RX interrupt it confirms the pending flag,
// reads the frame size, reads every buffer word and presents each one as an
// AXI-stream beat (tkeep/tlast on the final beat), then clears the pending
// flag. Zero or oversized frames are dropped and counted.
// Ports:
//   clk_i, reset_i (async, active-high)
//   addr_o/write_en_o/read_en_o/op_size_o/write_data_o : register port out
//   read_data_i/read_data_v_i                          : register port in
//   rx_interrupt_pending_i                             : controller RX irq
//   m_axis_*                                           : frame stream out
//   packets_o/drops_o                                  : wrapping counters
//   busy_o                                             : not in IDLE
module eth_rx_drain
  import eth_rx_drain_pkg::*;
#(
  parameter int unsigned buf_size_p       = 2048,
  parameter int unsigned axis_width_p     = 64,
  parameter int unsigned reg_addr_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic [reg_addr_width_p-1:0] addr_o,
  output logic                        write_en_o,
  output logic                        read_en_o,
  output logic [1:0]                  op_size_o,
  output logic [axis_width_p-1:0]     write_data_o,
  input  logic [axis_width_p-1:0]     read_data_i,
  input  logic                        read_data_v_i,
  input  logic                        rx_interrupt_pending_i,
  output logic [axis_width_p-1:0]     m_axis_tdata_o,
  output logic [axis_width_p/8-1:0]   m_axis_tkeep_o,
  output logic                        m_axis_tlast_o,
  output logic                        m_axis_tvalid_o,
  input  logic                        m_axis_tready_i,
  output logic [15:0]                 packets_o,
  output logic [15:0]                 drops_o,
  output logic                        busy_o
);

  localparam int unsigned KeepW = axis_width_p / 8;
  localparam int unsigned CntW  = $clog2(buf_size_p) + 1;

  state_e                      state_q, state_d;
  logic                        issued_q, issued_d;  // read strobe already sent
  logic [CntW-1:0]             words_q, words_d;
  logic [CntW-1:0]             idx_q, idx_d;
  logic [2:0]                  rem_q, rem_d;        // size mod 8
  logic [reg_addr_width_p-1:0] addr_q, addr_d;
  logic                        wr_en_q, wr_en_d;
  logic                        rd_en_q, rd_en_d;
  logic [1:0]                  op_q, op_d;
  logic [axis_width_p-1:0]     wdata_q, wdata_d;
  logic [axis_width_p-1:0]     tdata_q, tdata_d;
  logic [KeepW-1:0]            tkeep_q, tkeep_d;
  logic                        tlast_q, tlast_d;
  logic                        tvalid_q, tvalid_d;
  logic [15:0]                 packets_q, packets_d;
  logic [15:0]                 drops_q, drops_d;
  logic                        busy_q, busy_d;

  logic [31:0] rd_word;
  logic        last_beat;

  assign rd_word   = read_data_i[31:0];
  assign last_beat = (idx_q == words_q - CntW'(1));

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    words_d   = words_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    op_d      = op_q;
    wdata_d   = wdata_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q;
    packets_d = packets_q;
    drops_d   = drops_q;

    unique case (state_q)
      StInit: begin
        wr_en_d = 1'b1;
        addr_d  = reg_addr_width_p'(RegRxIntEn);
        op_d    = OpSize4;
        wdata_d = axis_width_p'(1);
        state_d = StIdle;
      end
      StIdle: begin
        issued_d = 1'b0;
        if (rx_interrupt_pending_i) state_d = StRdPend;
      end
      StRdPend: begin
        if (!issued_q) begin
          rd_en_d  = 1'b1;
          addr_d   = reg_addr_width_p'(RegRxPend);
          op_d     = OpSize4;
          issued_d = 1'b1;
        end else if (read_data_v_i) begin
          issued_d = 1'b0;
          state_d  = (rd_word == 32'd1) ? StRdSize : StIdle;
        end
      end
      StRdSize: begin
        if (!issued_q) begin
          rd_en_d  = 1'b1;
          addr_d   = reg_addr_width_p'(RegRxSize);
          op_d     = OpSize4;
          issued_d = 1'b1;
        end else if (read_data_v_i) begin
          issued_d = 1'b0;
          if (rd_word == 32'd0 || rd_word > buf_size_p) begin
            state_d = StDrop;
          end else begin
            // Size is bounded by buf_size_p here, so the cast cannot truncate.
            words_d = CntW'((rd_word + 32'd7) >> 3);
            rem_d   = rd_word[2:0];
            idx_d   = '0;
            state_d = StRdData;
          end
        end
      end
      StRdData: begin
        if (!issued_q) begin
          rd_en_d  = 1'b1;
          addr_d   = reg_addr_width_p'(RegBufBase) + (reg_addr_width_p'(idx_q) << 3);
          op_d     = OpSize8;
          issued_d = 1'b1;
        end else if (read_data_v_i) begin
          issued_d = 1'b0;
          tdata_d  = read_data_i;
          tvalid_d = 1'b1;
          tlast_d  = last_beat;
          tkeep_d  = last_beat ? KeepW'(last_keep(rem_q)) : '1;
          state_d  = StStream;
        end
      end
      StStream: begin
        if (m_axis_tready_i) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            state_d = StClear;
          end else begin
            idx_d   = idx_q + CntW'(1);
            state_d = StRdData;
          end
        end
      end
      StClear: begin
        wr_en_d   = 1'b1;
        addr_d    = reg_addr_width_p'(RegRxPend);
        op_d      = OpSize4;
        wdata_d   = axis_width_p'(1);
        packets_d = packets_q + 16'd1;
        state_d   = StIdle;
      end
      StDrop: begin
        wr_en_d = 1'b1;
        addr_d  = reg_addr_width_p'(RegRxPend);
        op_d    = OpSize4;
        wdata_d = axis_width_p'(1);
        drops_d = drops_q + 16'd1;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StInit;
      issued_q  <= 1'b0;
      words_q   <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      op_q      <= OpSize4;
      wdata_q   <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      packets_q <= '0;
      drops_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      words_q   <= words_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      packets_q <= packets_d;
      drops_q   <= drops_d;
      busy_q    <= busy_d;
    end
  end

  assign addr_o          = addr_q;
  assign write_en_o      = wr_en_q;
  assign read_en_o       = rd_en_q;
  assign op_size_o       = op_q;
  assign write_data_o    = wdata_q;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tkeep_o  = tkeep_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign packets_o       = packets_q;
  assign drops_o         = drops_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_eth_rx_drain.sv
// Self-checking bench for eth_rx_drain with a behavioural controller model and
// a stream scoreboard.
module tb_eth_rx_drain;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] addr_o;
  logic        write_en_o, read_en_o;
  logic [1:0]  op_size_o;
  logic [63:0] write_data_o;
  logic [63:0] read_data = '0;
  logic        read_data_v = 1'b0;
  logic        rx_pend;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid;
  logic        tready = 1'b1;
  logic [15:0] packets_o, drops_o;
  logic        busy_o;

  eth_rx_drain #(
    .buf_size_p      (2048),
    .axis_width_p    (64),
    .reg_addr_width_p(16)
  ) dut (
    .clk_i                 (clk),
    .reset_i               (reset_i),
    .addr_o                (addr_o),
    .write_en_o            (write_en_o),
    .read_en_o             (read_en_o),
    .op_size_o             (op_size_o),
    .write_data_o          (write_data_o),
    .read_data_i           (read_data),
    .read_data_v_i         (read_data_v),
    .rx_interrupt_pending_i(rx_pend),
    .m_axis_tdata_o        (tdata),
    .m_axis_tkeep_o        (tkeep),
    .m_axis_tlast_o        (tlast),
    .m_axis_tvalid_o       (tvalid),
    .m_axis_tready_i       (tready),
    .packets_o             (packets_o),
    .drops_o               (drops_o),
    .busy_o                (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  typedef struct {logic [15:0] a; logic [63:0] d; logic [1:0] op;} wr_t;

  beat_t       sb[$];
  wr_t         wr_log[$];
  int          vectors = 0, miscompares = 0;
  int          beats_seen = 0, rd_buf_cnt = 0, stall_cnt = 0;
  bit          stall_mode = 1'b0, tready_fix = 1'b1;

  // Controller model
  logic [63:0] mem [256];
  logic [31:0] rx_size = '0;
  int          post_cnt = 0, clr_cnt = 0;
  assign rx_pend = (post_cnt != clr_cnt);

  always @(posedge clk) begin
    read_data_v <= 1'b0;
    if (read_en_o) begin
      read_data_v <= 1'b1;
      if (addr_o == 16'h1010)      read_data <= {63'd0, rx_pend};
      else if (addr_o == 16'h1004) read_data <= {32'hDEAD_BEEF, rx_size};
      else                         read_data <= mem[addr_o[10:3]];
    end
    if (write_en_o && addr_o == 16'h1010 && write_data_o == 64'd1) clr_cnt <= clr_cnt + 1;
  end

  // Ready is changed just after the edge so the negedge monitor sees exactly
  // the value the DUT samples on the next rising edge.
  always @(posedge clk) begin
    #1;
    tready = stall_mode ? ($urandom_range(0, 99) >= 30) : tready_fix;
  end

  // Stream / register-port monitor
  logic [72:0] held;
  bit          held_v = 1'b0;
  always @(negedge clk) begin
    if (reset_i) begin
      held_v = 1'b0;
    end else begin
      if (write_en_o || read_en_o) begin
        vectors++;
        if (write_en_o && read_en_o) begin
          miscompares++;
          $display("FAIL strobe_overlap: both strobes high at %0t, want exclusive", $time);
        end
      end
      if (write_en_o) wr_log.push_back('{a: addr_o, d: write_data_o, op: op_size_o});
      if (read_en_o) begin
        vectors++;
        if (op_size_o !== ((addr_o < 16'h1000) ? 2'b11 : 2'b10)) begin
          miscompares++;
          $display("FAIL read_op_size: addr %h got %b", addr_o, op_size_o);
        end
        if (addr_o < 16'h1000) rd_buf_cnt++;
      end
      if (tvalid) begin
        if (held_v) begin
          vectors++;
          if ({tdata, tkeep, tlast} !== held) begin
            miscompares++;
            $display("FAIL stall_stable: got %h want %h", {tdata, tkeep, tlast}, held);
          end
        end
        if (tready) begin
          held_v = 1'b0;
          beats_seen++;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL beat_unexpected: got %h want no beat", {tdata, tkeep, tlast});
          end else begin
            beat_t e;
            e = sb.pop_front();
            if ({tdata, tkeep, tlast} !== {e.d, e.k, e.l}) begin
              miscompares++;
              $display("FAIL beat_data: got %h/%h/%b want %h/%h/%b",
                       tdata, tkeep, tlast, e.d, e.k, e.l);
            end
          end
        end else begin
          stall_cnt++;
          held   = {tdata, tkeep, tlast};
          held_v = 1'b1;
        end
      end else if (held_v) begin
        vectors++;
        miscompares++;
        held_v = 1'b0;
        $display("FAIL valid_dropped: tvalid 0 during stall, want 1");
      end
    end
  end

  task automatic push_expected(input int size);
    int words, rem;
    words = (size + 7) / 8;
    rem   = size % 8;
    for (int i = 0; i < words; i++) begin
      beat_t b;
      b.d = mem[i];
      b.l = (i == words - 1);
      b.k = (b.l && rem != 0) ? 8'(8'hFF >> (8 - rem)) : 8'hFF;
      sb.push_back(b);
    end
  endtask

  task automatic load_frame(input int size);
    int words;
    words = (size + 7) / 8;
    if (words > 256) words = 256;
    for (int i = 0; i < words; i++) mem[i] = {$urandom, $urandom};
    rx_size = 32'(size);
    if (size != 0 && size <= 2048) push_expected(size);
    post_cnt++;
  endtask

  task automatic wait_ctr(input bit use_drops, input logic [15:0] target, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if ((use_drops ? drops_o : packets_o) == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    settle(3);
    vectors++;
    if ({write_en_o, read_en_o, tvalid, tlast, busy_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00000", {write_en_o, read_en_o, tvalid, tlast, busy_o});
    end
    vectors++;
    if (op_size_o !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_op_size: got %b want 10", op_size_o);
    end
    vectors++;
    if ({addr_o, write_data_o, tdata, tkeep} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr %h wdata %h tdata %h tkeep %h want 0",
               addr_o, write_data_o, tdata, tkeep);
    end
    vectors++;
    if ({packets_o, drops_o} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got %h/%h want 0/0", packets_o, drops_o);
    end
    wr_log.delete();
    @(negedge clk);
    reset_i = 1'b0;
    settle(10);
    vectors++;
    if (wr_log.size() != 1) begin
      miscompares++;
      $display("FAIL init_write_count: got %0d want 1", wr_log.size());
    end else if ({wr_log[0].a, wr_log[0].d, wr_log[0].op} !== {16'h1014, 64'd1, 2'b10}) begin
      miscompares++;
      $display("FAIL init_write: got %h=%h op %b want 1014=1 op 10",
               wr_log[0].a, wr_log[0].d, wr_log[0].op);
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL init_idle_busy: got %b want 0", busy_o);
    end
  endtask

  task automatic test_full_frame();
    int b0;
    bit ok;
    b0 = beats_seen;
    load_frame(64);
    wait_ctr(1'b0, 16'd1, 400, ok);
    settle(10);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL full_timeout: packets %0d want 1", packets_o);
    end
    vectors++;
    if (beats_seen - b0 != 8 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL full_beats: got %0d left %0d want 8 left 0", beats_seen - b0, sb.size());
    end
    vectors++;
    if ({wr_log[$].a, wr_log[$].d, wr_log[$].op} !== {16'h1010, 64'd1, 2'b10}) begin
      miscompares++;
      $display("FAIL full_clear: got %h=%h op %b want 1010=1 op 10",
               wr_log[$].a, wr_log[$].d, wr_log[$].op);
    end
  endtask

  task automatic test_partial();
    int b0;
    bit ok;
    b0 = beats_seen;
    load_frame(61);
    wait_ctr(1'b0, 16'd2, 400, ok);
    settle(10);
    vectors++;
    if (!ok || beats_seen - b0 != 8 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL partial: ok %0b beats %0d left %0d want 1/8/0", ok, beats_seen - b0, sb.size());
    end
  endtask

  task automatic test_drop();
    int b0, w0, clears;
    bit ok1, ok2;
    b0 = beats_seen;
    w0 = wr_log.size();
    load_frame(0);
    wait_ctr(1'b1, 16'd1, 100, ok1);
    settle(10);
    load_frame(2049);
    wait_ctr(1'b1, 16'd2, 100, ok2);
    settle(10);
    clears = 0;
    for (int i = w0; i < wr_log.size(); i++) if (wr_log[i].a == 16'h1010) clears++;
    vectors++;
    if (!(ok1 && ok2) || drops_o !== 16'd2) begin
      miscompares++;
      $display("FAIL drop_count: got %0d want 2", drops_o);
    end
    vectors++;
    if (packets_o !== 16'd2 || beats_seen != b0) begin
      miscompares++;
      $display("FAIL drop_no_beats: packets %0d beats %0d want 2/0", packets_o, beats_seen - b0);
    end
    vectors++;
    if (clears != 2) begin
      miscompares++;
      $display("FAIL drop_clears: got %0d want 2", clears);
    end
  endtask

  task automatic test_stall();
    int b0, r0, s0;
    bit ok;
    b0 = beats_seen;
    r0 = rd_buf_cnt;
    s0 = stall_cnt;
    stall_mode = 1'b1;
    load_frame(1464);
    wait_ctr(1'b0, 16'd3, 8000, ok);
    stall_mode = 1'b0;
    settle(10);
    vectors++;
    if (!ok || beats_seen - b0 != 183 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL stall_beats: ok %0b got %0d left %0d want 183", ok, beats_seen - b0, sb.size());
    end
    vectors++;
    if (rd_buf_cnt - r0 != 183) begin
      miscompares++;
      $display("FAIL stall_reads: got %0d want 183", rd_buf_cnt - r0);
    end
    vectors++;
    if (stall_cnt == s0) begin
      miscompares++;
      $display("FAIL stall_exercised: got 0 stalls want >0");
    end
  endtask

  task automatic test_reset_mid();
    int b0, inits;
    bit found, ok;
    tready_fix = 1'b1;
    b0 = beats_seen;
    load_frame(80);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (beats_seen == b0 + 2 && tvalid) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midreset_beat3: got %0d beats want 2 then valid", beats_seen - b0);
    end
    reset_i = 1'b1;
    #1;
    vectors++;
    if ({write_en_o, read_en_o, tvalid, tlast, busy_o} !== 5'b0 || {addr_o, tdata, tkeep} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: flags %b addr %h tdata %h tkeep %h want 0",
               {write_en_o, read_en_o, tvalid, tlast, busy_o}, addr_o, tdata, tkeep);
    end
    vectors++;
    if ({packets_o, drops_o} !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_counters: got %h/%h want 0/0", packets_o, drops_o);
    end
    sb.delete();
    wr_log.delete();
    settle(2);
    @(negedge clk);
    reset_i = 1'b0;
    b0 = beats_seen;
    push_expected(80);  // frame is still pending in the controller
    wait_ctr(1'b0, 16'd1, 600, ok);
    settle(10);
    inits = 0;
    foreach (wr_log[i]) if (wr_log[i].a == 16'h1014) inits++;
    vectors++;
    if (inits != 1) begin
      miscompares++;
      $display("FAIL midreset_init: got %0d init writes want 1", inits);
    end
    vectors++;
    if (!ok || beats_seen - b0 != 10 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_redeliver: ok %0b beats %0d left %0d want 10/0",
               ok, beats_seen - b0, sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_partial();
    test_drop();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
